// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: mode codes, per-polynomial length/tap tables,
// seed fix-up and the multi-step LFSR advance used by the word generator.
package prbs_pkg;

    localparam int SEED_W    = 31;
    localparam int MAX_WIDTH = 64;

    localparam logic [2:0] MODE_PRBS7  = 3'd0;
    localparam logic [2:0] MODE_PRBS9  = 3'd1;
    localparam logic [2:0] MODE_PRBS15 = 3'd2;
    localparam logic [2:0] MODE_PRBS23 = 3'd3;
    localparam logic [2:0] MODE_PRBS31 = 3'd4;

    typedef logic [SEED_W-1:0] prbs_state_t;

    typedef struct packed {
        prbs_state_t            state;
        logic [MAX_WIDTH-1:0]   word;
    } prbs_adv_t;

    // Codes 5..7 fall through to PRBS31 in every table below.
    function automatic prbs_state_t prbs_mask(input logic [2:0] mode);
        case (mode)
            MODE_PRBS7:  return 31'h0000_007F;
            MODE_PRBS9:  return 31'h0000_01FF;
            MODE_PRBS15: return 31'h0000_7FFF;
            MODE_PRBS23: return 31'h007F_FFFF;
            default:     return 31'h7FFF_FFFF;
        endcase
    endfunction

    // Tap bit positions (tap number minus one) into the state vector.
    function automatic logic [4:0] prbs_tap1(input logic [2:0] mode);
        case (mode)
            MODE_PRBS7:  return 5'd6;
            MODE_PRBS9:  return 5'd8;
            MODE_PRBS15: return 5'd14;
            MODE_PRBS23: return 5'd22;
            default:     return 5'd30;
        endcase
    endfunction

    function automatic logic [4:0] prbs_tap2(input logic [2:0] mode);
        case (mode)
            MODE_PRBS7:  return 5'd5;
            MODE_PRBS9:  return 5'd4;
            MODE_PRBS15: return 5'd13;
            MODE_PRBS23: return 5'd17;
            default:     return 5'd27;
        endcase
    endfunction

    // An all-zero LFSR never leaves zero, so a zero seed becomes all-ones.
    function automatic prbs_state_t seed_fixup(input prbs_state_t seed,
                                               input logic [2:0]  mode);
        prbs_state_t masked;
        masked = seed & prbs_mask(mode);
        return (masked == '0) ? prbs_mask(mode) : masked;
    endfunction

    // Advances the state by width serial steps; the first generated bit
    // ends up at word[width-1], the last at word[0].
    function automatic prbs_adv_t prbs_advance(input prbs_state_t state,
                                               input logic [2:0]  mode,
                                               input int          width);
        prbs_adv_t   r;
        prbs_state_t mask;
        logic [4:0]  t1;
        logic [4:0]  t2;
        logic        fb;
        mask    = prbs_mask(mode);
        t1      = prbs_tap1(mode);
        t2      = prbs_tap2(mode);
        r.state = state;
        r.word  = '0;
        for (int k = 0; k < MAX_WIDTH; k++) begin
            if (k < width) begin
                fb      = r.state[t1] ^ r.state[t2];
                r.state = {r.state[SEED_W-2:0], fb} & mask;
                r.word  = {r.word[MAX_WIDTH-2:0], fb};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/prbs_gen_multi_step_comb.sv
// Purely combinational WIDTH-step unroll of the selected PRBS polynomial.
module prbs_step_comb
    import prbs_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [SEED_W-1:0] i_state,
    input  logic [2:0]        i_mode,
    output logic [SEED_W-1:0] o_next_state,
    output logic [WIDTH-1:0]  o_word
);

    prbs_adv_t w_adv;
    logic      w_unused_word_bits;

    always_comb begin
        w_adv = prbs_advance(i_state, i_mode, WIDTH);
    end

    assign o_next_state       = w_adv.state;
    assign o_word             = w_adv.word[WIDTH-1:0];
    assign w_unused_word_bits = ^w_adv.word;

endmodule

// File: rtl/prbs_gen_multi.sv
// Run-time selectable PRBS7..PRBS31 word source with valid/ready output,
// seed/mode reload, single-bit error injection and transfer/error counters.
module prbs_gen_multi
    import prbs_pkg::*;
#(
    parameter int          WIDTH        = 8,
    parameter logic [2:0]  DEFAULT_MODE = 3'd4,
    parameter logic [30:0] DEFAULT_SEED = 31'h5979_57A0,
    parameter int          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       mode,
    input  logic [30:0]      seed,
    input  logic             load,
    input  logic             inject_err,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       mode_q,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam prbs_state_t      RST_STATE = seed_fixup(DEFAULT_SEED, DEFAULT_MODE);
    localparam logic [WIDTH-1:0] LSB_ONE   = WIDTH'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    prbs_state_t      r_state;
    logic [2:0]       r_mode;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_pend;
    logic [CNT_W-1:0] r_word_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    prbs_state_t      w_next_state;
    logic [WIDTH-1:0] w_word;
    logic             w_xfer;
    logic             w_write;
    logic             w_consume;

    prbs_step_comb #(.WIDTH(WIDTH)) u_step (
        .i_state      (r_state),
        .i_mode       (r_mode),
        .o_next_state (w_next_state),
        .o_word       (w_word)
    );

    // A new word is written when the slot is empty (priming) or being
    // drained; load wins and leaves the slot empty for one cycle.
    assign w_xfer    = r_valid & out_ready;
    assign w_write   = ~load & (~r_valid | out_ready);
    assign w_consume = w_write & r_pend;

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= RST_STATE;
            r_mode     <= DEFAULT_MODE;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_pend     <= 1'b0;
            r_word_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (w_xfer) begin
                r_word_cnt <= r_word_cnt + CNT_ONE;
            end

            if (load) begin
                r_state <= seed_fixup(seed, mode);
                r_mode  <= mode;
                r_valid <= 1'b0;
            end else if (w_write) begin
                r_state <= w_next_state;
                r_data  <= w_word ^ (r_pend ? LSB_ONE : '0);
                r_valid <= 1'b1;
            end

            // A strobe arriving while a flip is already pending is absorbed.
            if (w_consume) begin
                r_pend    <= 1'b0;
                r_err_cnt <= r_err_cnt + CNT_ONE;
            end else if (inject_err) begin
                r_pend <= 1'b1;
            end
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign mode_q    = r_mode;
    assign word_cnt  = r_word_cnt;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_prbs_gen_multi.sv
// Self-checking bench for prbs_gen_multi: an 8-bit and a 1-bit instance share
// stimulus and are compared against a recurrence-based PRBS scoreboard.
module tb_prbs_gen_multi;

    localparam logic [30:0] DEF_SEED = 31'h5979_57A0;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  mode;
    logic [30:0] seed;
    logic        load;
    logic        inject_err;
    logic        out_ready;

    logic [7:0]  d8;
    logic        v8;
    logic [2:0]  mq8;
    logic [31:0] wc8;
    logic [31:0] ec8;
    logic [0:0]  d1;
    logic        v1;
    logic [2:0]  mq1;
    logic [31:0] wc1;
    logic [31:0] ec1;

    int checks = 0;
    int errors = 0;

    prbs_gen_multi #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .seed       (seed),
        .load       (load),
        .inject_err (inject_err),
        .out_data   (d8),
        .out_valid  (v8),
        .out_ready  (out_ready),
        .mode_q     (mq8),
        .word_cnt   (wc8),
        .err_cnt    (ec8)
    );

    prbs_gen_multi #(.WIDTH(1)) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .seed       (seed),
        .load       (load),
        .inject_err (inject_err),
        .out_data   (d1),
        .out_valid  (v1),
        .out_ready  (out_ready),
        .mode_q     (mq1),
        .word_cnt   (wc1),
        .err_cnt    (ec1)
    );

    always #5 clk = ~clk;

    // Reference: bit sequence a[n] = a[n-N] ^ a[n-t2]; queues hold the last N
    // bits oldest first, seeded with seed[N-1] .. seed[0].
    bit          q8[$];
    bit          q1[$];
    int          m_n;
    int          m_t2;
    bit          exp_valid;
    logic [7:0]  exp_d8;
    logic [7:0]  exp_raw8;
    bit          exp_d1;
    logic [31:0] exp_cnt;
    logic [31:0] exp_err;
    logic [2:0]  exp_mode;
    bit          pend;
    logic [7:0]  first_def8;

    function automatic void model_load(input logic [2:0] md, input logic [30:0] sd);
        longint      mask;
        logic [30:0] s;
        case (md)
            3'd0:    begin m_n = 7;  m_t2 = 6;  end
            3'd1:    begin m_n = 9;  m_t2 = 5;  end
            3'd2:    begin m_n = 15; m_t2 = 14; end
            3'd3:    begin m_n = 23; m_t2 = 18; end
            default: begin m_n = 31; m_t2 = 28; end
        endcase
        mask = (64'd1 << m_n) - 1;
        s = sd & mask[30:0];
        if (s == 31'd0) s = mask[30:0];
        q8.delete();
        q1.delete();
        for (int j = m_n - 1; j >= 0; j--) begin
            q8.push_back(s[j]);
            q1.push_back(s[j]);
        end
    endfunction

    function automatic bit model_bit(input bit sel);
        bit b;
        if (sel) begin
            b = q1[0] ^ q1[m_n - m_t2];
            q1.push_back(b);
            void'(q1.pop_front());
        end else begin
            b = q8[0] ^ q8[m_n - m_t2];
            q8.push_back(b);
            void'(q8.pop_front());
        end
        return b;
    endfunction

    function automatic logic [7:0] model_word8();
        logic [7:0] w = '0;
        for (int k = 0; k < 8; k++) w = {w[6:0], model_bit(1'b0)};
        return w;
    endfunction

    function automatic void model_reset();
        model_load(3'd4, DEF_SEED);
        exp_mode  = 3'd4;
        exp_valid = 1'b0;
        exp_cnt   = '0;
        exp_err   = '0;
        pend      = 1'b0;
    endfunction

    // Advances the scoreboard by the rules for the edge about to occur, then
    // steps to the following falling edge where outputs are sampled.
    task automatic tick();
        bit wr;
        if (exp_valid && out_ready) exp_cnt++;
        wr = !load && (!exp_valid || out_ready);
        if (load) begin
            model_load(mode, seed);
            exp_mode  = mode;
            exp_valid = 1'b0;
        end else if (wr) begin
            exp_raw8  = model_word8();
            exp_d8    = exp_raw8;
            exp_d1    = model_bit(1'b1);
            if (pend) begin
                exp_d8[0] = ~exp_d8[0];
                exp_d1    = ~exp_d1;
            end
            exp_valid = 1'b1;
        end
        if (wr && pend) begin
            pend = 1'b0;
            exp_err++;
        end else if (inject_err) begin
            pend = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_valid"}, 64'(v8),  64'(exp_valid));
        chk({tag, "_mode"},  64'(mq8), 64'(exp_mode));
        chk({tag, "_wcnt"},  64'(wc8), 64'(exp_cnt));
        chk({tag, "_ecnt"},  64'(ec8), 64'(exp_err));
        chk({tag, "_w1cnt"}, 64'(wc1), 64'(exp_cnt));
        if (exp_valid) begin
            chk({tag, "_data8"}, 64'(d8), 64'(exp_d8));
            chk({tag, "_data1"}, 64'(d1), 64'(exp_d1));
        end
    endtask

    task automatic do_load(input logic [2:0] md, input logic [30:0] sd);
        load = 1'b1;
        mode = md;
        seed = sd;
        tick();
        load = 1'b0;
    endtask

    // 1-bit instance: compare every bit and find when the state (the last N
    // output bits) first returns to the seed value 1.
    task automatic period_run(input logic [2:0] md, input int n, input int period);
        logic [30:0] win;
        logic [30:0] mask;
        int          mism;
        int          ret;
        mask = 31'((64'd1 << n) - 1);
        do_load(md, 31'd1);
        tick();
        win  = 31'd1;
        mism = 0;
        ret  = -1;
        for (int i = 0; i < period; i++) begin
            if (d1[0] !== exp_d1) mism++;
            win = {win[29:0], d1[0]} & mask;
            if (win == 31'd1 && ret < 0) ret = i + 1;
            tick();
        end
        chk($sformatf("period%0d_bits", n), 64'(mism), 64'd0);
        chk($sformatf("period%0d_return", n), 64'(ret), 64'(period));
    endtask

    initial begin
        bit          bits[$];
        int          mism;
        logic [7:0]  held;
        logic [31:0] cnt_before;

        reset      = 1'b0;
        load       = 1'b0;
        inject_err = 1'b0;
        mode       = 3'd0;
        seed       = 31'd0;
        out_ready  = 1'b0;
        model_reset();

        #12;
        chk("rst_valid", 64'(v8),  64'd0);
        chk("rst_data",  64'(d8),  64'd0);
        chk("rst_wcnt",  64'(wc8), 64'd0);
        chk("rst_ecnt",  64'(ec8), 64'd0);
        chk("rst_mode",  64'(mq8), 64'd4);
        chk("rst_data1", 64'(d1),  64'd0);

        @(negedge clk);
        reset = 1'b1;
        tick();
        first_def8 = exp_d8;
        check_all("prime");

        // PRBS7 from all-ones seed; bitstream period 127.
        do_load(3'd0, 31'h7F);
        check_all("load7");
        tick();
        chk("prbs7_first", 64'(d8), 64'h02);
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            check_all("prbs7_run");
            for (int k = 7; k >= 0; k--) bits.push_back(d8[k]);
            tick();
        end
        mism = 0;
        for (int i = 0; i + 127 < bits.size(); i++) begin
            if (bits[i] != bits[i + 127]) mism++;
        end
        chk("prbs7_period", 64'(mism), 64'd0);

        // Stall for 10 cycles with two inject pulses inside it.
        do_load(3'd4, 31'h1234_5678);
        tick();
        for (int i = 0; i < 5; i++) tick();
        out_ready = 1'b0;
        tick();
        held       = exp_d8;
        cnt_before = exp_cnt;
        for (int i = 0; i < 10; i++) begin
            inject_err = (i == 3 || i == 6);
            tick();
            chk("stall_data", 64'(d8),  64'(held));
            chk("stall_wcnt", 64'(wc8), 64'(cnt_before));
        end
        inject_err = 1'b0;
        chk("stall_ecnt", 64'(ec8), 64'd0);
        out_ready = 1'b1;
        tick();
        check_all("inject");
        chk("inject_diff", 64'(d8 ^ exp_raw8), 64'h01);
        chk("inject_ecnt", 64'(ec8), 64'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check_all("post_inject");
        end

        // Zero seed on PRBS15, loaded during an active transfer.
        cnt_before = exp_cnt;
        do_load(3'd2, 31'd0);
        check_all("load15");
        chk("load15_xfer_cnt", 64'(wc8), 64'(cnt_before + 1));
        chk("load15_mode", 64'(mq8), 64'd2);
        tick();
        chk("load15_first", 64'(d8), 64'h00);
        check_all("prbs15_prime");
        for (int i = 0; i < 8; i++) begin
            tick();
            check_all("prbs15_run");
        end

        // Full-period runs on the 1-bit instance, then sampled long modes.
        period_run(3'd0, 7, 127);
        period_run(3'd1, 9, 511);
        period_run(3'd2, 15, 32767);
        for (int m = 3; m <= 4; m++) begin
            do_load(3'(m), 31'd1);
            tick();
            mism = 0;
            for (int i = 0; i < 1000; i++) begin
                if (d1[0] !== exp_d1) mism++;
                tick();
            end
            chk($sformatf("sample_mode%0d", m), 64'(mism), 64'd0);
        end

        // Randomised handshake, loads, modes and injections.
        for (int i = 0; i < 400; i++) begin
            out_ready  = ($urandom_range(0, 3) != 0);
            load       = ($urandom_range(0, 31) == 0);
            mode       = 3'($urandom_range(0, 7));
            seed       = 31'($urandom);
            inject_err = ($urandom_range(0, 15) == 0);
            tick();
            check_all("rand");
        end
        load       = 1'b0;
        inject_err = 1'b0;
        out_ready  = 1'b1;
        tick();
        tick();

        // Asynchronous reset in the middle of a streaming cycle.
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", 64'(v8),  64'd0);
        chk("arst_data",  64'(d8),  64'd0);
        chk("arst_wcnt",  64'(wc8), 64'd0);
        chk("arst_ecnt",  64'(ec8), 64'd0);
        chk("arst_mode",  64'(mq8), 64'd4);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("arst_first", 64'(d8), 64'(first_def8));
        check_all("arst_prime");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
